// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - ball position/velocity FSM (serve, move, reflect guard); BALL_SPEEDUP_EN enables paddle-hit speedup
module ball_motion #(
    parameter int SCREEN_X     = 640,
    parameter int SCREEN_Y     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [1:0] bounce,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [7:0] ball_size_x,
    output logic [7:0] ball_size_y,
    output logic       serving
);
    localparam int X_MAX = SCREEN_X - BALL_SIZE;
    localparam int Y_MAX = SCREEN_Y - BALL_SIZE;
    localparam logic [9:0] X_C = 10'(X_MAX / 2);
    localparam logic [9:0] Y_C = 10'(Y_MAX / 2);
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [2:0] SPD_INIT = 3'(SPEED_INIT);

    typedef enum logic [1:0] {S_SERVE, S_MOVE, S_GUARD} state_e;

    state_e           state_q, state_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic             serve_dir_q, serve_dir_d;
    logic [2:0]       speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             serving_q;
    logic             rst_sync_q;

    // Signed step with clamping so the ball never wraps past the playfield edges.
    function automatic logic [9:0] step(input logic [9:0] p, input logic dir,
                                        input logic [2:0] spd, input int lim);
        int n;
        n = dir ? int'(p) + int'(spd) : int'(p) - int'(spd);
        if (n < 0)
            return 10'd0;
        else if (n > lim)
            return 10'(lim);
        else
            return 10'(n);
    endfunction

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        serve_dir_d = serve_dir_q;
        speed_d     = speed_q;
        cnt_d       = cnt_q;
        if (rst_sync_q) begin
            if (state_q == S_SERVE) begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_MOVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end else if (bounce == 2'd3) begin
                x_d         = X_C;
                y_d         = Y_C;
                speed_d     = SPD_INIT;
                serve_dir_d = ~serve_dir_q;
                dir_x_d     = ~serve_dir_q;
                cnt_d       = '0;
                state_d     = S_SERVE;
            end else begin
                if (state_q == S_MOVE && bounce == 2'd1) begin
                    dir_x_d = ~dir_x_q;
`ifdef BALL_SPEEDUP_EN
                    speed_d = (int'(speed_q) >= SPEED_MAX) ? 3'(SPEED_MAX) : speed_q + 3'd1;
`endif
                    state_d = S_GUARD;
                end else if (state_q == S_MOVE && bounce == 2'd2) begin
                    dir_y_d = ~dir_y_q;
                    state_d = S_GUARD;
                end else if (state_q == S_GUARD && bounce == 2'd0) begin
                    state_d = S_MOVE;
                end
                // Motion uses the freshly reflected direction and speed.
                if (frame_tick) begin
                    x_d = step(x_q, dir_x_d, speed_d, X_MAX);
                    y_d = step(y_q, dir_y_d, speed_d, Y_MAX);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SERVE;
            x_q         <= X_C;
            y_q         <= Y_C;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            serve_dir_q <= 1'b1;
            speed_q     <= SPD_INIT;
            cnt_q       <= '0;
            serving_q   <= 1'b1;
            rst_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            serve_dir_q <= serve_dir_d;
            speed_q     <= speed_d;
            cnt_q       <= cnt_d;
            serving_q   <= (state_d == S_SERVE);
            rst_sync_q  <= 1'b1;
        end
    end

    assign ball_pos_x  = x_q;
    assign ball_pos_y  = y_q;
    assign ball_size_x = 8'(BALL_SIZE);
    assign ball_size_y = 8'(BALL_SIZE);
    assign serving     = serving_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - randomized bench for ball_motion against a behavioural game model
module tb_ball_motion;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic [1:0] bounce;
    logic [9:0] ball_pos_x, ball_pos_y;
    logic [7:0] ball_size_x, ball_size_y;
    logic       serving;

    ball_motion dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .bounce     (bounce),
        .ball_pos_x (ball_pos_x),
        .ball_pos_y (ball_pos_y),
        .ball_size_x(ball_size_x),
        .ball_size_y(ball_size_y),
        .serving    (serving)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Game model: positions in pixels, velocities as +1/-1 signs times a speed.
`ifdef BALL_SPEEDUP_EN
    localparam int SPD_TOP = 6;
`else
    localparam int SPD_TOP = 2;
`endif
    int  mx, my, mdx, mdy, mspd, mframes, mlaunch;
    bit  m_serve, m_guard, m_awake;

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        mx = 316; my = 236; mdx = 1; mdy = 1; mspd = 2;
        mframes = 0; mlaunch = 1;
        m_serve = 1; m_guard = 0; m_awake = 0;
    endtask

    task automatic model_step(input int tick, input int b);
        if (!m_awake) begin
            m_awake = 1;
            return;
        end
        if (m_serve) begin
            if (tick != 0) begin
                mframes++;
                if (mframes == 60) begin
                    mframes = 0;
                    m_serve = 0;
                    m_guard = 0;
                end
            end
            return;
        end
        if (b == 3) begin
            mx = 316; my = 236; mspd = 2;
            mlaunch = -mlaunch; mdx = mlaunch;
            mframes = 0; m_serve = 1; m_guard = 0;
            return;
        end
        if (!m_guard && b == 1) begin
            mdx = -mdx;
            mspd = (mspd + 1 > SPD_TOP) ? SPD_TOP : mspd + 1;
            m_guard = 1;
        end else if (!m_guard && b == 2) begin
            mdy = -mdy;
            m_guard = 1;
        end else if (m_guard && b == 0) begin
            m_guard = 0;
        end
        if (tick != 0) begin
            mx = clamp(mx + mdx * mspd, 632);
            my = clamp(my + mdy * mspd, 472);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"}, int'(ball_pos_x), mx);
        check({tag, "_y"}, int'(ball_pos_y), my);
        check({tag, "_serving"}, int'(serving), int'(m_serve));
    endtask

    int r;

    initial begin
        reset_n = 1'b0;
        frame_tick = 1'b0;
        bounce = 2'd0;
        model_reset();
        repeat (3) @(negedge clock);
        check_outputs("reset");
        check("size_x", int'(ball_size_x), 8);
        check("size_y", int'(ball_size_y), 8);
        reset_n = 1'b1;

        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (cyc % 5000 == 2500) begin
                #2 reset_n = 1'b0;
                #1 model_reset();
                check_outputs("async_rst");
                @(negedge clock);
                check_outputs("rst_hold");
                reset_n = 1'b1;
            end
            if (cyc < 150) begin
                // Straight serve with point codes that must be ignored while serving.
                frame_tick = 1'b1;
                bounce = (cyc < 40) ? 2'd3 : 2'd0;
            end else begin
                frame_tick = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    r = int'($urandom_range(0, 999));
                    if ((cyc / 1000) % 2 == 1)
                        bounce = (r < 2) ? 2'd3 : 2'd0;
                    else if (r < 800)
                        bounce = 2'd0;
                    else if (r < 890)
                        bounce = 2'd1;
                    else if (r < 985)
                        bounce = 2'd2;
                    else
                        bounce = 2'd3;
                end
            end
            @(posedge clock);
            model_step(int'(frame_tick), int'(bounce));
            @(negedge clock);
            check_outputs("run");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
